// File: rtl/serial_adder.sv
// Purpose   : bit-serial unsigned adder (LSB-first, one bit per clock) built
//             from two half_adder cells and a registered carry.
// Latency   : accept on edge T -> out_valid high after edge T+WIDTH; II = WIDTH+2.
// Backpres. : result held in DONE while out_ready=0; in_ready only in IDLE.
//
// Ports (serial_adder):
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand pair on a/b is valid
//   in_ready   block accepts operands (IDLE only)
//   a, b       WIDTH-bit unsigned operands, sampled on the accepting edge
//   out_valid  sum/carry_out hold a completed result (DONE)
//   out_ready  consumer accepts the result
//   sum        a + b modulo 2^WIDTH
//   carry_out  bit WIDTH of a + b
//   busy       high in ADD or DONE
// WIDTH legal range: 2..32.

// Purpose   : one-bit half adder cell.
// Latency   : combinational.
// Backpres. : none.
module half_adder (
    input  logic i_x,
    input  logic i_y,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_x ^ i_y;
    assign o_c = i_x & i_y;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
);
    // Counter only has to reach WIDTH-1; clog2 covers that for WIDTH >= 2.
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry_out;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic               w_p;
    logic               w_g1;
    logic               w_s;
    logic               w_g2;
    logic               w_carry_nxt;

    // HA1 adds the current operand bits, HA2 folds in the running carry.
    // g1 and g2 can never both be 1, so OR forms the full-adder carry.
    half_adder u_ha1 (
        .i_x (r_a_sh[0]),
        .i_y (r_b_sh[0]),
        .o_s (w_p),
        .o_c (w_g1)
    );

    half_adder u_ha2 (
        .i_x (w_p),
        .i_y (r_carry),
        .o_s (w_s),
        .o_c (w_g2)
    );

    assign w_carry_nxt = w_g1 | w_g2;

    // Handshake/status outputs come straight from registers updated with
    // the state, so there is no input-to-output combinational path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a_sh      <= a;
                        r_b_sh      <= b;
                        r_carry     <= 1'b0;
                        r_cnt       <= '0;
                        r_sum       <= '0;
                        r_state     <= S_ADD;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end

                S_ADD: begin
                    // New sum bits enter at the MSB; after WIDTH shifts the
                    // first (LSB) bit has arrived at position 0.
                    r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                    r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_carry <= w_carry_nxt;
                    if (r_cnt == CNT_LAST) begin
                        r_carry_out <= w_carry_nxt;
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                S_DONE: begin
                    // Result stays on sum/carry_out after leaving DONE; only
                    // the next accept clears sum.
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign carry_out = r_carry_out;

endmodule

// File: tb/tb_serial_adder.sv
// Purpose   : self-checking bench for serial_adder (WIDTH=8) against a
//             transaction-level model (plain a+b, cycle countdown).
// Latency   : n/a.
// Backpres. : exercises out_ready held low and random release delays.
module tb_serial_adder;
    localparam int W = 8;
    localparam int PH_IDLE = 0;
    localparam int PH_ADD  = 1;
    localparam int PH_DONE = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         busy;

    int n_chk = 0;
    int n_err = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle time %0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The result is plain a+b; timing is modelled as "WIDTH edges after accept".
    int         m_ph = PH_IDLE;
    bit         m_init = 0;
    int         m_left = 0;
    logic [W:0] m_full = '0;
    logic [W-1:0] m_sum = '0;
    logic       m_carry = 1'b0;
    int         cyc = 0;
    int         n_acc = 0;
    int         acc_cyc = 0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_ph    = PH_IDLE;
            m_sum   = '0;
            m_carry = 1'b0;
            m_init  = 1;
        end else if (m_init) begin
            case (m_ph)
                PH_IDLE: if (in_valid) begin
                    m_full  = {1'b0, a} + {1'b0, b};
                    m_sum   = '0;
                    m_left  = W;
                    m_ph    = PH_ADD;
                    n_acc++;
                    acc_cyc = cyc;
                end
                PH_ADD: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_ph    = PH_DONE;
                        m_sum   = m_full[W-1:0];
                        m_carry = m_full[W];
                    end
                end
                default: if (out_ready) m_ph = PH_IDLE;
            endcase
        end
    end

    // Compare every cycle once the model has seen a reset edge.
    always @(negedge clk) begin
        if (m_init) begin
            chk("in_ready",  64'(in_ready),  64'(m_ph == PH_IDLE));
            chk("out_valid", 64'(out_valid), 64'(m_ph == PH_DONE));
            chk("busy",      64'(busy),      64'(m_ph != PH_IDLE));
            chk("carry_out", 64'(carry_out), 64'(m_carry));
            if (m_ph != PH_ADD)
                chk("sum", 64'(sum), 64'(m_sum));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_accept(output int t_acc);
        int prev;
        bit ok;
        prev = n_acc;
        ok = 0;
        t_acc = -1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk); #1;
            if (n_acc != prev) begin
                ok = 1;
                t_acc = acc_cyc;
            end
        end
        if (!ok) chk("accept_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_done(output int t_done);
        bit ok;
        ok = 0;
        t_done = -1;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1;
                t_done = cyc;
            end
        end
        if (!ok) chk("done_timeout", 64'd1, 64'd0);
    endtask

    // Full operation: present operands, check latency and literal result,
    // release out_ready after rdy_delay cycles, return with DUT in IDLE.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic [W-1:0] exp_s, input logic exp_c,
                          input int rdy_delay);
        int t_acc;
        int t_done;
        @(posedge clk); #1;
        a = xa; b = xb; in_valid = 1'b1;
        out_ready = (rdy_delay == 0);
        wait_accept(t_acc);
        in_valid = 1'b0;
        wait_done(t_done);
        chk("latency", 64'(t_done - t_acc), 64'(W));
        chk("result_sum", 64'(sum), 64'(exp_s));
        chk("result_carry", 64'(carry_out), 64'(exp_c));
        if (rdy_delay > 0) begin
            repeat (rdy_delay) @(posedge clk);
            #1 out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int t1, t2, t_rel, t_done;
        bit saw_valid;
        logic [W-1:0] ra, rb;
        logic [W:0]   rs;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_carry", 64'(carry_out), 64'd0);

        // Directed results
        run_op(8'd3,   8'd5,   8'd8,   1'b0, 0);
        run_op(8'd255, 8'd1,   8'd0,   1'b1, 0);
        run_op(8'd255, 8'd255, 8'd254, 1'b1, 0);

        // Back-pressure: hold DONE 5 cycles with 7+7 waiting on the inputs
        @(posedge clk); #1;
        a = 8'd1; b = 8'd1; in_valid = 1'b1; out_ready = 1'b0;
        wait_accept(t1);
        in_valid = 1'b0;
        wait_done(t_done);
        a = 8'd7; b = 8'd7; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_sum", 64'(sum), 64'd2);
            chk("bp_carry", 64'(carry_out), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        t_rel = cyc;
        out_ready = 1'b0;
        wait_accept(t2);
        in_valid = 1'b0;
        chk("bp_accept_edge", 64'(t2), 64'(t_rel + 1));
        wait_done(t_done);
        chk("bp_sum2", 64'(sum), 64'd14);
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Back-to-back with in_valid and out_ready high throughout
        a = 8'd1; b = 8'd2; in_valid = 1'b1; out_ready = 1'b1;
        wait_accept(t1);
        a = 8'd100; b = 8'd27;
        wait_done(t_done);
        chk("b2b_sum1", 64'(sum), 64'd3);
        wait_accept(t2);
        in_valid = 1'b0;
        chk("b2b_spacing", 64'(t2 - t1), 64'(W + 2));
        wait_done(t_done);
        chk("b2b_sum2", 64'(sum), 64'd127);
        chk("b2b_carry2", 64'(carry_out), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset mid-ADD (cnt=4) aborts 200+100
        a = 8'd200; b = 8'd100; in_valid = 1'b1;
        wait_accept(t1);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_sum", 64'(sum), 64'd0);
        chk("abort_carry", 64'(carry_out), 64'd0);
        saw_valid = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1;
        end
        chk("abort_no_valid", 64'(saw_valid), 64'd0);
        run_op(8'd10, 8'd20, 8'd30, 1'b0, 0);

        // Operands changed during ADD are ignored
        @(posedge clk); #1;
        a = 8'h0F; b = 8'h01; in_valid = 1'b1; out_ready = 1'b1;
        wait_accept(t1);
        in_valid = 1'b0;
        a = 8'hFF; b = 8'hFF;
        wait_done(t_done);
        chk("chg_sum", 64'(sum), 64'h10);
        chk("chg_carry", 64'(carry_out), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Randomized operations with random release delays
        for (int k = 0; k < 40; k++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            if (k == 0) begin ra = '0; rb = '0; end
            rs = {1'b0, ra} + {1'b0, rb};
            run_op(ra, rb, rs[W-1:0], rs[W], int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial unsigned adder built from two `half_adder` cells plus a registered carry. It accepts a pair of WIDTH-bit operands over a valid/ready handshake and adds them LSB-first, one bit per clock. It returns the WIDTH-bit sum and carry-out over a second valid/ready handshake. It sits directly downstream of the half adder as the first sequential consumer of that cell, and trades area for latency in the arithmetic datapath.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 2..32.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on `clk` rising edge.
- `in_valid`  in  1  operand pair on `a`/`b` is valid.
- `in_ready`  out  1  block can accept operands; high only in IDLE.
- `a`  in  WIDTH  operand A, unsigned.
- `b`  in  WIDTH  operand B, unsigned.
- `out_valid`  out  1  `sum`/`carry_out` hold a completed result.
- `out_ready`  in  1  consumer accepts the result.
- `sum`  out  WIDTH  a + b modulo 2^WIDTH.
- `carry_out`  out  1  bit WIDTH of a + b.
- `busy`  out  1  high in ADD or DONE.

## Operation
- The FSM has three states: IDLE, ADD and DONE. Reset forces IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, load `a` into shift register A_sh and `b` into B_sh. Clear the carry register, clear `sum`, set bit counter cnt=0, and go to ADD.
  - Operand values are sampled only on the accepting edge. Later changes on `a`/`b` are ignored.
- ADD, one bit per cycle:
  - HA1 computes `A_sh[0]`, `B_sh[0]` -> p, g1.
  - HA2 computes p, carry -> s, g2.
  - carry <= g1 | g2.
  - `sum` <= {s, sum[WIDTH-1:1]}, so new bits enter at the MSB and shift right.
  - A_sh and B_sh shift right by one with zero fill.
  - cnt <= cnt+1.
  - When cnt==WIDTH-1, go to DONE on the same edge. `carry_out` is loaded with g1 | g2 from that final bit.
- DONE:
  - `out_valid`=1. `sum` and `carry_out` are held stable.
  - On `out_ready`=1, go to IDLE. `sum`/`carry_out` keep their values until the next accept clears `sum`.
  - If `out_ready` stays 0, DONE holds indefinitely (back-pressure).
- `in_valid` is ignored in ADD and DONE. No operand is queued, and the producer must hold its operands until it sees `in_ready`.
- The counter is wide enough to hold WIDTH-1 (clog2(WIDTH) bits). It never wraps during an operation.
- Arithmetic is unsigned; overflow appears only on `carry_out`.

## Timing
- Reset values (after any edge with `rst_n`=0):
  - state IDLE, `in_ready`=1, `out_valid`=0, `busy`=0
  - `sum`=0, `carry_out`=0, carry=0, cnt=0, A_sh=B_sh=0
- Reset dominates all other inputs on the same edge. Reset mid-ADD or mid-DONE aborts the operation and discards the result; no `out_valid` pulse follows.
- Latency: if the accept happens on edge T, then `out_valid` rises after edge T+WIDTH (for WIDTH=8, 8 cycles).
- Minimum initiation interval is WIDTH+2 cycles, with `out_ready` tied high:
  - edge T+WIDTH enters DONE
  - edge T+WIDTH+1 returns to IDLE
  - earliest next accept is edge T+WIDTH+2
- `in_ready`, `out_valid` and `busy` are decoded directly from state registers, with no combinational path from inputs. `sum` and `carry_out` are register outputs.

## Test plan
- Reset, then `a`=3, `b`=5 with `in_valid` for 1 cycle -> `out_valid` after 8 cycles, `sum`=8, `carry_out`=0; `in_ready` low throughout ADD/DONE.
- `a`=255, `b`=1 -> `sum`=0, `carry_out`=1; then `a`=255, `b`=255 -> `sum`=254, `carry_out`=1.
- `out_ready` held 0 for 5 cycles in DONE with `in_valid`=1 and `a`=7, `b`=7 presented -> `sum`/`carry_out`/`out_valid` stable. The new operands are not accepted until the cycle after `out_ready` rises; that second result is 14.
- Back-to-back with `out_ready`=1 and `in_valid`=1 continuously (1+2 then 100+27) -> accepts spaced exactly 10 cycles apart (WIDTH=8); results 3 and 127.
- `rst_n`=0 for one cycle at cnt=4 during 200+100 -> all outputs return to reset values, no `out_valid`. A subsequent 10+20 yields 30 with the full latency.
- Operands changed on `a`/`b` during ADD (start 0x0F+0x01, then drive 0xFF/0xFF) -> result still `sum`=0x10, `carry_out`=0.
